fire_scheduler: RTL and testbench
=================================

# fire_scheduler

Drives the `fire` index of a generated `circuit` model, one transition at a time, so the synchronous simulation of an asynchronous circuit progresses autonomously. Each selection picks one currently excited transition (signal whose next value differs from its present value), using round-robin or, optionally, LFSR-random choice. Sits between the testbench/host control and the `circuit` instance. Also detects quiescence (no excited transitions) and enforces a firing budget.

## Interface
- `N`, 8: number of transitions (inputs + stateful signals), indices 0..N-1 as in `circuit`.
- `W`, 4: width of `fire`; must satisfy 2^W > N so that the all-ones value is a non-firing idle code.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: pulse; begin a run from IDLE.
- `stop` in 1: level; abort the run and return to IDLE.
- `step_mode` in 1: 1 = fire only on `step` pulses; 0 = free-running.
- `step` in 1: pulse; permits one firing in step mode.
- `excited` in N: bit i = 1 when transition i is enabled.
- `max_fires` in 16: firing budget; 0 = unlimited.
- `fire` out W: transition index to `circuit`; all-ones = idle.
- `busy` out 1: high in SELECT/FIRE/SETTLE/WAIT_STEP.
- `stable` out 1: sticky; run ended because `excited` was all-zero.
- `done` out 1: sticky; run ended because the budget was reached.
- `fire_count` out 16: transitions fired in the current run, saturating at 0xFFFF.

## Operation
- States: IDLE, SELECT, FIRE, SETTLE, WAIT_STEP.
- IDLE: `fire` = all-ones. On `start` -> clear `fire_count`, `stable`, `done` -> SELECT. A `start` pulse while not IDLE is ignored.
- SELECT: sample `excited`.
  - All-zero -> set `stable` -> IDLE.
  - `max_fires` != 0 and `fire_count` == `max_fires` -> set `done` -> IDLE. The budget check takes priority over the stable check.
  - `step_mode` = 1 and no pending step -> WAIT_STEP.
  - Otherwise choose index k -> FIRE.
- Round-robin choice: k is the first set bit of `excited` at or after `ptr`, wrapping from N-1 to 0. After firing, `ptr` = k+1, or 0 if k = N-1. `ptr` resets to 0.
- FIRE: `fire` = k for exactly one cycle; `fire_count` increments, saturating. Then -> SETTLE.
- SETTLE: `fire` = all-ones for one cycle so that the `circuit` register update propagates into `excited`. Then -> SELECT.
- WAIT_STEP: `fire` = all-ones. On `step` -> SELECT with one step credit. The credit is consumed in FIRE. A `step` arriving outside WAIT_STEP is latched as a single credit; extra pulses are dropped.
- `stop` has priority over all other transitions: next state IDLE, `fire` = all-ones. `stable`/`done` are unchanged.
- Clearing `step_mode` while in WAIT_STEP -> SELECT next cycle.
- Excited bits at indices >= N do not exist. `fire` never carries a value >= N other than all-ones.

## Timing
- Reset values: `fire` = all-ones, `busy` = 0, `stable` = 0, `done` = 0, `fire_count` = 0, state IDLE, `ptr` = 0, step credit 0, LFSR = seed constant.
- Reset asserted mid-run forces the reset values immediately, without waiting for a clock edge.
- All outputs are registered.
- `start` sampled at edge t -> SELECT in cycle t+1 -> first `fire` in cycle t+2.
- Free-running throughput: one firing every 3 cycles (SELECT, FIRE, SETTLE).
- `stable`/`done` are set and `busy` drops on the edge that leaves SELECT.
- `fire_count` updates on the edge that leaves FIRE.

## Configuration
- `FIRE_SCHEDULER_LFSR_EN` defined: SELECT uses a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1), stepped once per SELECT. Rotate `excited` by (LFSR mod N), then take the first set bit, giving pseudo-random interleavings. `ptr` is unused.
- Not defined: round-robin as above; no LFSR logic.

## Test plan
- N=8, `excited` = 0b00000101 held, `max_fires` = 4, `start` -> `fire` sequence 0,2,0,2 with all-ones between firings; `done` = 1, `fire_count` = 4, `busy` = 0.
- `excited` = 0 at `start` -> no firing; `stable` = 1 two cycles after `start`; `fire_count` = 0.
- `step_mode` = 1, `excited` = 0xFF, three `step` pulses 10 cycles apart -> exactly 3 firings (0,1,2), each 2 cycles after its `step`; WAIT_STEP between.
- Free run with `excited` = 0x80, then clear bit 7 after the first firing -> `fire` = 7 once, then `stable` = 1 on the next SELECT.
- `stop` asserted in FIRE -> next cycle `fire` = all-ones, IDLE, `fire_count` retains its value; `reset` asserted mid-run -> all outputs at reset values before the next edge.
- With `FIRE_SCHEDULER_LFSR_EN`, `excited` = 0xFF, 64 firings -> every index 0..7 fired at least once; the sequence from reset is identical across two runs.

Source files
------------

// File: rtl/fire_scheduler.sv
// Steps a generated circuit model one excited transition at a time; detects quiescence and enforces a firing budget.
// Round-robin selection by default; define FIRE_SCHEDULER_LFSR_EN for LFSR-randomised selection.
module fire_scheduler #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          step_mode_i,
  input  logic          step_i,
  input  logic [N-1:0]  excited_i,
  input  logic [15:0]   max_fires_i,
  output logic [W-1:0]  fire_o,
  output logic          busy_o,
  output logic          stable_o,
  output logic          done_o,
  output logic [15:0]   fire_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_FIRE,
    S_SETTLE,
    S_WAIT_STEP
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] fire_q, fire_d;
  logic         busy_q, busy_d;
  logic         stable_q, stable_d;
  logic         done_q, done_d;
  logic [15:0]  fire_count_q, fire_count_d;
  logic         credit_q, credit_d;

  logic [W-1:0] pick;
  logic         found;
  int           base_idx;

`ifdef FIRE_SCHEDULER_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign base_idx = int'(lfsr_q) % N;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_SELECT) lfsr_d = {lfsr_q[14:0], lfsr_fb};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  logic [W-1:0] ptr_q, ptr_d;

  assign base_idx = int'(ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_SELECT && state_d == S_FIRE)
      ptr_d = (pick == W'(N - 1)) ? '0 : pick + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  // First excited index at or after base_idx, wrapping at N.
  always_comb begin : pick_search
    int          idx;
    logic [N-1:0] shifted;
    pick    = '1;
    found   = 1'b0;
    idx     = 0;
    shifted = '0;
    for (int i = 0; i < N; i++) begin
      idx = base_idx + i;
      if (idx >= N) idx = idx - N;
      shifted = excited_i >> idx;
      if (!found && shifted[0]) begin
        found = 1'b1;
        pick  = idx[W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    stable_d     = stable_q;
    done_d       = done_q;
    fire_count_d = fire_count_q;
    credit_d     = credit_q | step_i;

    if (state_q == S_FIRE) begin
      credit_d = step_i;
      if (fire_count_q != 16'hFFFF) fire_count_d = fire_count_q + 16'd1;
    end

    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            fire_count_d = '0;
            stable_d     = 1'b0;
            done_d       = 1'b0;
            state_d      = S_SELECT;
          end
        end
        S_SELECT: begin
          if (max_fires_i != 16'd0 && fire_count_q == max_fires_i) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (!found) begin
            stable_d = 1'b1;
            state_d  = S_IDLE;
          end else if (step_mode_i && !credit_q) begin
            state_d = S_WAIT_STEP;
          end else begin
            state_d = S_FIRE;
          end
        end
        S_FIRE:      state_d = S_SETTLE;
        S_SETTLE:    state_d = S_SELECT;
        S_WAIT_STEP: if (step_i || !step_mode_i) state_d = S_SELECT;
        default:     state_d = S_IDLE;
      endcase
    end

    fire_d = (state_d == S_FIRE) ? pick : '1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      fire_q       <= '1;
      busy_q       <= 1'b0;
      stable_q     <= 1'b0;
      done_q       <= 1'b0;
      fire_count_q <= '0;
      credit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fire_q       <= fire_d;
      busy_q       <= busy_d;
      stable_q     <= stable_d;
      done_q       <= done_d;
      fire_count_q <= fire_count_d;
      credit_q     <= credit_d;
    end
  end

  assign fire_o       = fire_q;
  assign busy_o       = busy_q;
  assign stable_o     = stable_q;
  assign done_o       = done_q;
  assign fire_count_o = fire_count_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler: budget, quiescence, step mode, stop, reset and start-while-busy.
module tb_fire_scheduler;

  localparam int N = 8;
  localparam int W = 4;
  localparam logic [W-1:0] IDLE_CODE = 4'hF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, step_mode, step;
  logic [N-1:0]  excited;
  logic [15:0]   max_fires;
  logic [W-1:0]  fire;
  logic          busy, stable, done;
  logic [15:0]   fire_count;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fire_scheduler #(.N(N), .W(W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .stop_i       (stop),
    .step_mode_i  (step_mode),
    .step_i       (step),
    .excited_i    (excited),
    .max_fires_i  (max_fires),
    .fire_o       (fire),
    .busy_o       (busy),
    .stable_o     (stable),
    .done_o       (done),
    .fire_count_o (fire_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; stop = 0; step_mode = 0; step = 0;
    excited = '0; max_fires = '0;
    tick();
    tick();
    check_cnt++;
    if (fire !== IDLE_CODE) $display("FAIL reset_fire: got %0h expected %0h", fire, IDLE_CODE);
    else pass_cnt++;
    check_cnt++;
    if ({busy, stable, done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, stable, done});
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", fire_count);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  // excited=0b101, budget 4: fires 0,2,0,2 at cycles 2,5,8,11 after start.
  task automatic test_budget;
    logic [W-1:0] seq [4];
    logic [W-1:0] exp_f;
    seq[0] = 4'd0; seq[1] = 4'd2; seq[2] = 4'd0; seq[3] = 4'd2;
    do_reset();
    excited = 8'b0000_0101; max_fires = 16'd4; step_mode = 0;
    pulse_start();
    for (int c = 1; c <= 13; c++) begin
      exp_f = (c % 3 == 2) ? seq[c / 3] : IDLE_CODE;
      check_cnt++;
      if (fire !== exp_f) $display("FAIL budget_fire_c%0d: got %0h expected %0h", c, fire, exp_f);
      else pass_cnt++;
      tick();
    end
    check_cnt++;
    if (done !== 1'b1) $display("FAIL budget_done: got %b expected 1", done);
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd4) $display("FAIL budget_count: got %0d expected 4", fire_count);
    else pass_cnt++;
    check_cnt++;
    if ({busy, stable} !== 2'b00) $display("FAIL budget_busy_stable: got %b expected 00", {busy, stable});
    else pass_cnt++;
  endtask

  // No excited transitions: stable after one SELECT; start also clears the earlier done.
  task automatic test_stable;
    excited = '0; max_fires = '0;
    pulse_start();
    check_cnt++;
    if ({busy, stable, done} !== 3'b100) $display("FAIL stable_select: got %b expected 100", {busy, stable, done});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, stable, done} !== 3'b010) $display("FAIL stable_flags: got %b expected 010", {busy, stable, done});
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd0) $display("FAIL stable_count: got %0d expected 0", fire_count);
    else pass_cnt++;
    check_cnt++;
    if (fire !== IDLE_CODE) $display("FAIL stable_fire: got %0h expected %0h", fire, IDLE_CODE);
    else pass_cnt++;
  endtask

  task automatic test_step_mode;
    logic [W-1:0] exp_f;
    do_reset();
    excited = 8'hFF; max_fires = '0; step_mode = 1'b1;
    pulse_start();
    for (int c = 0; c < 5; c++) tick();
    check_cnt++;
    if ({busy, fire} !== {1'b1, IDLE_CODE}) $display("FAIL step_wait: got busy=%b fire=%0h expected busy=1 fire=f", busy, fire);
    else pass_cnt++;
    for (int n = 0; n < 3; n++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        exp_f = (c == 2) ? W'(n) : IDLE_CODE;
        check_cnt++;
        if (fire !== exp_f) $display("FAIL step%0d_fire_c%0d: got %0h expected %0h", n, c, fire, exp_f);
        else pass_cnt++;
        tick();
      end
    end
    check_cnt++;
    if (fire_count !== 16'd3) $display("FAIL step_count: got %0d expected 3", fire_count);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL step_busy: got %b expected 1", busy);
    else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    step_mode = 1'b0;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL step_stop_busy: got %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single_then_quiet;
    do_reset();
    excited = 8'h80; max_fires = '0;
    pulse_start();
    tick();
    check_cnt++;
    if (fire !== 4'd7) $display("FAIL quiet_fire7: got %0h expected 7", fire);
    else pass_cnt++;
    excited = 8'h00;
    tick();
    check_cnt++;
    if (fire !== IDLE_CODE) $display("FAIL quiet_settle: got %0h expected %0h", fire, IDLE_CODE);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, stable} !== 2'b10) $display("FAIL quiet_select: got %b expected 10", {busy, stable});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, stable, done} !== 3'b010) $display("FAIL quiet_stable: got %b expected 010", {busy, stable, done});
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd1) $display("FAIL quiet_count: got %0d expected 1", fire_count);
    else pass_cnt++;
  endtask

  task automatic test_stop;
    do_reset();
    excited = 8'hFF; max_fires = '0;
    pulse_start();
    tick();
    check_cnt++;
    if (fire !== 4'd0) $display("FAIL stop_prefire: got %0h expected 0", fire);
    else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_cnt++;
    if ({busy, fire} !== {1'b0, IDLE_CODE}) $display("FAIL stop_idle: got busy=%b fire=%0h expected busy=0 fire=f", busy, fire);
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd1) $display("FAIL stop_count: got %0d expected 1", fire_count);
    else pass_cnt++;
    tick();
    tick();
    check_cnt++;
    if ({busy, stable, done, fire} !== {3'b000, IDLE_CODE}) $display("FAIL stop_stays_idle: got %b expected 000f", {busy, stable, done, fire});
    else pass_cnt++;
  endtask

  // Start pulse during FIRE is ignored; run still ends on budget 3.
  task automatic test_start_ignored;
    do_reset();
    excited = 8'hFF; max_fires = 16'd3;
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5);
      if (c == 8) begin
        check_cnt++;
        if (fire !== 4'd2) $display("FAIL busy_start_fire: got %0h expected 2", fire);
        else pass_cnt++;
      end
      tick();
    end
    start = 1'b0;
    check_cnt++;
    if ({busy, done} !== 2'b01) $display("FAIL busy_start_done: got %b expected 01", {busy, done});
    else pass_cnt++;
    check_cnt++;
    if (fire_count !== 16'd3) $display("FAIL busy_start_count: got %0d expected 3", fire_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    excited = 8'hFF; max_fires = '0;
    pulse_start();
    for (int c = 0; c < 4; c++) tick();
    check_cnt++;
    if ({busy, fire_count} !== {1'b1, 16'd1}) $display("FAIL midrst_pre: got busy=%b count=%0d expected busy=1 count=1", busy, fire_count);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    check_cnt++;
    if ({fire, busy, stable, done, fire_count} !== {IDLE_CODE, 3'b000, 16'd0})
      $display("FAIL midrst_async: got fire=%0h flags=%b count=%0d expected fire=f flags=000 count=0", fire, {busy, stable, done}, fire_count);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef FIRE_SCHEDULER_LFSR_EN
  task automatic run_lfsr(output logic [W-1:0] seq [64], output int got);
    do_reset();
    excited = 8'hFF; max_fires = 16'd64;
    got = 0;
    pulse_start();
    for (int c = 0; c < 400 && got < 64; c++) begin
      if (fire !== IDLE_CODE) begin
        seq[got] = fire;
        got++;
      end
      tick();
    end
  endtask

  task automatic test_lfsr;
    logic [W-1:0] s1 [64];
    logic [W-1:0] s2 [64];
    logic [N-1:0] seen;
    int g1, g2;
    run_lfsr(s1, g1);
    run_lfsr(s2, g2);
    check_cnt++;
    if (g1 !== 64 || g2 !== 64) $display("FAIL lfsr_fire_total: got %0d,%0d expected 64", g1, g2);
    else pass_cnt++;
    seen = '0;
    for (int i = 0; i < g1; i++) if (s1[i] < N) seen[s1[i]] = 1'b1;
    for (int k = 0; k < N; k++) begin
      check_cnt++;
      if (seen[k] !== 1'b1) $display("FAIL lfsr_cover_%0d: got 0 expected 1", k);
      else pass_cnt++;
    end
    for (int i = 0; i < 64; i++) begin
      check_cnt++;
      if (s2[i] !== s1[i]) $display("FAIL lfsr_repeat_%0d: got %0h expected %0h", i, s2[i], s1[i]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_budget();
    test_stable();
    test_step_mode();
    test_single_then_quiet();
    test_stop();
    test_start_ignored();
    test_reset_mid();
`ifdef FIRE_SCHEDULER_LFSR_EN
    test_lfsr();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
